// File: rtl/lsu_align_unit.sv
// rtl/lsu_align_unit.sv - load/store alignment unit with split beats and bus handshake
module lsu_align_unit #(
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1,
    parameter int MAX_WAIT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : '0;

    function automatic logic [2:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] mask_of(input logic [1:0] sz);
        case (sz)
            2'b00:   mask_of = 4'b0001;
            2'b01:   mask_of = 4'b0011;
            default: mask_of = 4'b1111;
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       hi_q, hi_d;
    logic              err_q, err_d;
    logic              cross_q, cross_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              req_illegal_f3, req_cross, req_illegal;
    logic [1:0]        offset;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        mask8;
    logic [63:0]       wd64;
    logic [31:0]       r32, ld_ext;
    logic              in_beat, beat1;

    always_comb begin
        req_illegal_f3 = req_we ? (req_funct3 > 3'b010)
                                : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        req_cross      = ({1'b0, req_addr[1:0]} + size_of(req_funct3[1:0])) > 3'd4;
        req_illegal    = req_illegal_f3 | (!MISALIGN_EN & req_cross);
    end

    // Lane steering is done on the latched request so bus fields stay stable while waiting.
    always_comb begin
        offset    = addr_q[1:0];
        base_addr = {addr_q[ADDR_W-1:2], 2'b00};
        mask8     = {4'b0000, mask_of(f3_q[1:0])} << offset;
        wd64      = {32'h0, wdata_q} << {offset, 3'b000};
        r32       = 32'({hi_q, lo_q} >> {offset, 3'b000});
        case (f3_q[1:0])
            2'b00:   ld_ext = {{24{~f3_q[2] & r32[7]}}, r32[7:0]};
            2'b01:   ld_ext = {{16{~f3_q[2] & r32[15]}}, r32[15:0]};
            default: ld_ext = r32;
        endcase
    end

    always_comb begin
        in_beat   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
        beat1     = (state_q == S_BEAT1);
        req_ready = (state_q == S_IDLE);
        stall     = req_valid | (state_q != S_IDLE);
        mem_valid = in_beat;
        mem_we    = in_beat & we_q;
        mem_addr  = !in_beat ? '0 : (beat1 ? base_addr + ADDR_W'(4) : base_addr);
        mem_be    = !in_beat ? 4'b0000 : (beat1 ? mask8[7:4] : mask8[3:0]);
        mem_wdata = !(in_beat & we_q) ? 32'h0 : (beat1 ? wd64[63:32] : wd64[31:0]);
        rsp_valid = (state_q == S_DONE);
        rsp_err   = rsp_valid & err_q;
        rsp_rdata = (rsp_valid & !err_q & !we_q) ? ld_ext : 32'h0;
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;
        cross_d = cross_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cross_d = req_cross;
                    err_d   = req_illegal;
                    wait_d  = '0;
                    state_d = req_illegal ? S_DONE : S_BEAT0;
                end
            end
            S_BEAT0, S_BEAT1: begin
                if (mem_ready) begin
                    wait_d = '0;
                    if (beat1) begin
                        hi_d    = mem_rdata;
                        state_d = S_DONE;
                    end else begin
                        lo_d    = mem_rdata;
                        state_d = cross_q ? S_BEAT1 : S_DONE;
                    end
                end else if ((MAX_WAIT > 0) && (wait_q == WAIT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
            err_q   <= 1'b0;
            cross_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            cross_q <= cross_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_lsu_align_unit.sv
// tb/tb_lsu_align_unit.sv - scoreboard bench for lsu_align_unit (split and strict/timeout builds)
module tb_lsu_align_unit;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        rr_a, st_a, rv_a, re_a, mv_a, mw_a;
    logic [31:0] rd_a, ma_a, md_a;
    logic [3:0]  mb_a;
    logic        rr_b, st_b, rv_b, re_b, mv_b, mw_b;
    logic [31:0] rd_b, ma_b, md_b;
    logic [3:0]  mb_b;

    logic        sel = 1'b0;
    logic        o_req_ready, o_stall, o_rsp_valid, o_rsp_err, o_mem_valid, o_mem_we;
    logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    int    nvec = 0;
    int    nerr = 0;

    always #5 clk = ~clk;

    lsu_align_unit #(.ADDR_W(32), .MISALIGN_EN(1'b1), .MAX_WAIT(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(rr_a), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .stall(st_a),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(re_a), .mem_valid(mv_a), .mem_ready(mem_ready),
        .mem_we(mw_a), .mem_addr(ma_a), .mem_be(mb_a), .mem_wdata(md_a), .mem_rdata(mem_rdata)
    );

    lsu_align_unit #(.ADDR_W(32), .MISALIGN_EN(1'b0), .MAX_WAIT(4)) dut_strict (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(rr_b), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .stall(st_b),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(re_b), .mem_valid(mv_b), .mem_ready(mem_ready),
        .mem_we(mw_b), .mem_addr(ma_b), .mem_be(mb_b), .mem_wdata(md_b), .mem_rdata(mem_rdata)
    );

    assign o_req_ready = sel ? rr_b : rr_a;
    assign o_stall     = sel ? st_b : st_a;
    assign o_rsp_valid = sel ? rv_b : rv_a;
    assign o_rsp_err   = sel ? re_b : re_a;
    assign o_rsp_rdata = sel ? rd_b : rd_a;
    assign o_mem_valid = sel ? mv_b : mv_a;
    assign o_mem_we    = sel ? mw_b : mw_a;
    assign o_mem_addr  = sel ? ma_b : ma_a;
    assign o_mem_be    = sel ? mb_b : mb_a;
    assign o_mem_wdata = sel ? md_b : md_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_beat(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd);
        beat_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wd;
        beat_q.push_back(b);
    endtask

    task automatic exp_rsp(input logic [31:0] rd, input logic err, input int lat);
        rsp_t r;
        r.rdata = rd; r.err = err; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    // Starts at a negedge with the selected unit idle; ends at the negedge after the response.
    task automatic run(input logic s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                       input int w0, input int w1);
        int   cyc, beat, waited;
        bit   done;
        rsp_t e;
        sel = s;
        chk("req_ready_idle", {31'b0, o_req_ready}, 32'd1);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        #1;
        chk("stall_on_req", {31'b0, o_stall}, 32'd1);
        @(posedge clk); @(negedge clk);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        cyc = 1; beat = 0; waited = 0; done = 0;
        e.rdata = 32'h0; e.err = 1'b0; e.lat = 0;
        while (!done && cyc < 60) begin
            mem_ready = 1'b0;
            if (o_mem_valid) begin
                chk("beat_expected", {31'b0, beat_q.size() != 0}, 32'd1);
                if (beat_q.size() != 0) begin
                    chk("mem_we", {31'b0, o_mem_we}, {31'b0, beat_q[0].we});
                    chk("mem_addr", o_mem_addr, beat_q[0].addr);
                    chk("mem_be", {28'b0, o_mem_be}, {28'b0, beat_q[0].be});
                    chk("mem_wdata", o_mem_wdata, beat_q[0].wdata);
                    chk("stall_busy", {31'b0, o_stall}, 32'd1);
                    if (waited < ((beat == 0) ? w0 : w1)) begin
                        waited++;
                    end else begin
                        mem_ready = 1'b1;
                        mem_rdata = (beat == 0) ? rd0 : rd1;
                        void'(beat_q.pop_front());
                        beat++;
                        waited = 0;
                    end
                end
            end
            if (o_rsp_valid) begin
                chk("rsp_expected", {31'b0, rsp_q.size() != 0}, 32'd1);
                if (rsp_q.size() != 0) e = rsp_q.pop_front();
                chk("rsp_latency", cyc, e.lat);
                chk("rsp_rdata", o_rsp_rdata, e.rdata);
                chk("rsp_err", {31'b0, o_rsp_err}, {31'b0, e.err});
                done = 1;
            end else begin
                chk("rsp_quiet", {o_rsp_rdata[31:1], o_rsp_rdata[0] | o_rsp_err}, 32'h0);
            end
            if (!done) begin
                @(posedge clk); @(negedge clk);
                cyc++;
            end
        end
        chk("rsp_seen", {31'b0, done}, 32'd1);
        if (!e.err) chk("beats_left", beat_q.size(), 32'd0);
        beat_q.delete();
        mem_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rsp_pulse_end", {31'b0, o_rsp_valid}, 32'd0);
        chk("req_ready_after", {31'b0, o_req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        sel = 1'b0;
        chk("rst_mem_valid", {31'b0, o_mem_valid}, 32'd0);
        chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, o_rsp_err}, 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'h0);
        chk("rst_mem_we", {31'b0, o_mem_we}, 32'd0);
        chk("rst_mem_be", {28'b0, o_mem_be}, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        chk("rst_mem_wdata", o_mem_wdata, 32'h0);
        chk("rst_req_ready", {31'b0, o_req_ready}, 32'd1);
        chk("rst_stall", {31'b0, o_stall}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        exp_beat(1'b0, 32'h100, 4'b1111, 32'h0);
        exp_rsp(32'hDEADBEEF, 1'b0, 2);
        run(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0);

        exp_beat(1'b1, 32'h200, 4'b1000, 32'hA5000000);
        exp_rsp(32'h0, 1'b0, 2);
        run(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 32'h0, 0, 0);

        exp_beat(1'b0, 32'h200, 4'b1000, 32'h0);
        exp_rsp(32'hFFFFFFA5, 1'b0, 2);
        run(1'b0, 1'b0, 3'b000, 32'h203, 32'h0, 32'hA5000000, 32'h0, 0, 0);

        exp_beat(1'b0, 32'h200, 4'b1000, 32'h0);
        exp_rsp(32'h000000A5, 1'b0, 2);
        run(1'b0, 1'b0, 3'b100, 32'h203, 32'h0, 32'hA5000000, 32'h0, 0, 0);

        exp_beat(1'b0, 32'h100, 4'b1100, 32'h0);
        exp_beat(1'b0, 32'h104, 4'b0011, 32'h0);
        exp_rsp(32'h44332211, 1'b0, 3);
        run(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h22110000, 32'h00004433, 0, 0);

        exp_beat(1'b0, 32'h100, 4'b1100, 32'h0);
        exp_beat(1'b0, 32'h104, 4'b0011, 32'h0);
        exp_rsp(32'h44332211, 1'b0, 7);
        run(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 32'h22110000, 32'h00004433, 2, 2);

        exp_beat(1'b1, 32'hFFFFFFFC, 4'b1000, 32'h44000000);
        exp_beat(1'b1, 32'h00000000, 4'b0111, 32'h00112233);
        exp_rsp(32'h0, 1'b0, 3);
        run(1'b0, 1'b1, 3'b010, 32'hFFFFFFFF, 32'h11223344, 32'h0, 32'h0, 0, 0);

        exp_beat(1'b0, 32'h100, 4'b0110, 32'h0);
        exp_rsp(32'hFFFFBEEF, 1'b0, 2);
        run(1'b0, 1'b0, 3'b001, 32'h101, 32'h0, 32'h00BEEF00, 32'h0, 0, 0);

        exp_beat(1'b0, 32'h100, 4'b1100, 32'h0);
        exp_rsp(32'h00008001, 1'b0, 2);
        run(1'b0, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 32'h0, 0, 0);

        exp_beat(1'b1, 32'h1000, 4'b1000, 32'hEF000000);
        exp_beat(1'b1, 32'h1004, 4'b0001, 32'h000000BE);
        exp_rsp(32'h0, 1'b0, 3);
        run(1'b0, 1'b1, 3'b001, 32'h1003, 32'h0000BEEF, 32'h0, 32'h0, 0, 0);

        exp_rsp(32'h0, 1'b1, 1);
        run(1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0);
        exp_rsp(32'h0, 1'b1, 1);
        run(1'b0, 1'b1, 3'b100, 32'h100, 32'h12345678, 32'h0, 32'h0, 0, 0);

        exp_rsp(32'h0, 1'b1, 1);
        run(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 32'h0, 0, 0);
        exp_beat(1'b0, 32'h100, 4'b1100, 32'h0);
        exp_rsp(32'hFFFF8001, 1'b0, 2);
        run(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 32'h0, 0, 0);
        exp_beat(1'b0, 32'h100, 4'b1111, 32'h0);
        exp_rsp(32'hCAFEF00D, 1'b0, 5);
        run(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 32'h0, 3, 0);
        exp_beat(1'b0, 32'h100, 4'b1111, 32'h0);
        exp_rsp(32'h0, 1'b1, 5);
        run(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 32'h0, 1000, 0);

        sel = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h102; req_wdata = 32'h0;
        req_valid_a = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid_a = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h22110000;
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0;
        chk("beat1_valid", {31'b0, o_mem_valid}, 32'd1);
        chk("beat1_addr", o_mem_addr, 32'h104);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_valid", {31'b0, o_mem_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, o_req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("midrst_mem_addr", o_mem_addr, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("midrst_no_rsp", {31'b0, o_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_no_rsp", {31'b0, o_rsp_valid}, 32'd0);
        exp_beat(1'b0, 32'h200, 4'b1111, 32'h0);
        exp_rsp(32'h12345678, 1'b0, 2);
        run(1'b0, 1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 32'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
Parametrised load/store alignment unit that replaces the combinational byte-enable, store-rotate and load-extract logic in the memory stage. It accepts one load or store per request and drives a valid/ready data-memory bus. Word-crossing misaligned accesses are split into two bus beats, or rejected with an error when splitting is disabled. While an access is in flight, the unit raises a stall to the pipeline hazard logic.

Parameters:
ADDR_W, 32, byte-address width; beat addresses wrap modulo 2^ADDR_W.
MISALIGN_EN, 1, 1 = split word-crossing accesses into two beats; 0 = reject them with rsp_err.
MAX_WAIT, 0, maximum cycles mem_valid may wait for mem_ready before the access aborts with an error; 0 disables the timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
req_valid  in  1  memory-stage request present
req_ready  out  1  unit idle, request accepted this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I size/sign encoding (lb/lh/lw/lbu/lhu, sb/sh/sw)
req_addr  in  ADDR_W  byte address (ALU result)
req_wdata  in  32  store data, right-aligned
stall  out  1  hold pipeline (request pending or in flight)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned (MISALIGN_EN=0), illegal funct3, or timeout
mem_valid  out  1  bus beat request
mem_ready  in  1  bus accepts beat; read data valid in the same cycle
mem_we  out  1  write beat
mem_addr  out  ADDR_W  word-aligned beat address
mem_be  out  4  byte enables
mem_wdata  out  32  lane-aligned write data
mem_rdata  in  32  read data

Behaviour:
- States: IDLE, BEAT0, BEAT1, DONE. req_ready = (state==IDLE). stall = req_valid | (state!=IDLE).
- Accept: req_valid & req_ready. On accept, latch we, funct3, addr and wdata.
  - Legal access → BEAT0.
  - Illegal access → DONE with err=1. No bus activity occurs.
- Size: funct3[1:0] = 00 → 1 byte, 01 → 2 bytes, 10 → 4 bytes.
  - Illegal for loads: 011, 110, 111.
  - Illegal for stores: funct3 > 010.
- Offset = addr[1:0]. Cross = (offset + size) > 4. With MISALIGN_EN=0, cross is illegal. Misaligned accesses inside one word (for example sh at offset 1) always take a single beat.
- Beat address: beat0 = {addr[ADDR_W-1:2], 2'b00}; beat1 = beat0 + 4, wrapping.
- Byte enables: mask8 = ((1<<size)-1) << offset. beat0 be = mask8[3:0]; beat1 be = mask8[7:4].
- Write data: wd64 = {32'b0, wdata} << (8*offset). beat0 carries wd64[31:0]; beat1 carries wd64[63:32].
- BEAT0/BEAT1 handshake:
  - mem_valid=1. mem_we, mem_addr, mem_be and mem_wdata stay stable until mem_ready.
  - On mem_ready in BEAT0: capture rdata into lo. Go to BEAT1 if cross, else DONE.
  - On mem_ready in BEAT1: capture rdata into hi, then go to DONE.
- Load result:
  - r64 = {hi, lo} >> (8*offset).
  - Truncate r64 to size.
  - Sign-extend when funct3[2]=0; zero-extend when funct3[2]=1.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata and rsp_err are valid only while rsp_valid=1 and are 0 otherwise.
- Timeout (MAX_WAIT>0):
  - A wait counter resets on each beat entry and increments each cycle with mem_valid & !mem_ready.
  - When the counter reaches MAX_WAIT: go to DONE with err=1.
  - A write already committed in BEAT0 is not undone, and BEAT1 is not issued.
- Zero-wait latency (mem_ready tied 1), measured from the accept edge:
  - Single beat: rsp_valid 2 cycles after accept.
  - Split access: 3 cycles.
  - Error: 1 cycle.
- Back-to-back: the next request can be accepted in the cycle after rsp_valid, because req_ready is high again in IDLE.
- Reset: all state returns to IDLE. mem_valid, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_be, mem_addr and mem_wdata are 0. req_ready=1.
  - Reset mid-access aborts the access with no response.
  - The bus must tolerate a dropped mem_valid.

Test Plan:
- Aligned lw at 0x100, mem_rdata=0xDEADBEEF, mem_ready=1 → one beat at addr 0x100, be=1111; rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid 2 cycles after accept.
- sb wdata=0x000000A5 at 0x203 → be=1000, mem_wdata=0xA5000000, addr 0x200. Then lb at 0x203 with rdata 0xA5000000 → rsp_rdata=0xFFFFFFA5; lbu → 0x000000A5.
- Split lw at 0x102 (MISALIGN_EN=1): beat0 addr 0x100 be=1100 returns 0x22110000; beat1 addr 0x104 be=0011 returns 0x00004433 → rsp_rdata=0x44332211, response in 3 cycles. Repeat with mem_ready low for 2 cycles on each beat → mem_* held stable, response 7 cycles after accept.
- Split sw 0x11223344 at 0xFFFFFFFF (ADDR_W=32) → beat0 addr 0xFFFFFFFC be=1000 wdata=0x44000000; beat1 addr 0x00000000 (wrap) be=0111 wdata=0x00112233.
- Errors:
  - MISALIGN_EN=0, lh at 0x103 → no mem_valid; rsp_valid with rsp_err=1 and rdata 0 one cycle after accept.
  - Load funct3=011 → same error response.
  - MAX_WAIT=4 with mem_ready stuck low → rsp_err=1 after 4 wait cycles.
- Reset asserted during BEAT1 of a split load → mem_valid=0 and state IDLE immediately, no rsp_valid. After release, req_ready=1 and a new lw completes normally.
